// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, MDU results
// queue in an ordered buffer, drain into idle port cycles and are squashed on WAW.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_writereg,
    input  logic [31:0] wb_result,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_writereg,
    input  logic [31:0] mdu_result,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd,
    output logic        rf_src,
    output logic        stall_req,
    output logic [31:0] pend_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       buf_reg [DEPTH];
    logic [31:0]      buf_dat [DEPTH];
    logic [DEPTH-1:0] live_q, live_d, kill_vec;
    logic [PW-1:0]    head_q, tail_q;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             ready_q, stall_q;

    logic             pipe_req, enq, enq_killed;
    logic             head_valid, head_live, issue, pop;

    logic             rf_we_p1, rf_src_p1;
    logic [4:0]       rf_wa_p1;
    logic [31:0]      rf_wd_p1;

    // p0: port decision, squash and buffer bookkeeping
    always_comb begin
        pipe_req   = wb_regwrite && (wb_writereg != 5'd0);
        enq        = mdu_valid && ready_q && (mdu_writereg != 5'd0);
        enq_killed = pipe_req && (mdu_writereg == wb_writereg);
        for (int i = 0; i < DEPTH; i++) begin
            kill_vec[i] = pipe_req && (buf_reg[i] == wb_writereg);
        end
        head_valid = (count_q != '0);
        // A head squashed this very cycle is already treated as dead
        head_live  = head_valid && live_q[head_q] && !kill_vec[head_q];
        issue      = head_live && !pipe_req;
        pop        = head_valid && (issue || !head_live);
    end

    always_comb begin
        live_d = live_q & ~kill_vec;
        if (pop) begin
            live_d[head_q] = 1'b0;
        end
        if (enq) begin
            live_d[tail_q] = !enq_killed;
        end
        count_d = count_q + CW'(enq) - CW'(pop);
    end

    always_comb begin
        starve_d = starve_q;
        if (!head_live || issue) begin
            starve_d = '0;
        end else if (pipe_req && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pend_mask[buf_reg[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            buf_reg[tail_q] <= mdu_writereg;
            buf_dat[tail_q] <= mdu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            ready_q  <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            live_q   <= live_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            ready_q  <= (count_d < CW'(DEPTH));
            stall_q  <= (starve_d == SW'(STARVE_LIMIT));
            if (pop) begin
                head_q <= head_q + PW'(1);
            end
            if (enq) begin
                tail_q <= tail_q + PW'(1);
            end
        end
    end

    // p1: registered register-file write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_p1  <= 1'b0;
            rf_src_p1 <= 1'b0;
            rf_wa_p1  <= '0;
            rf_wd_p1  <= '0;
        end else begin
            rf_we_p1  <= pipe_req || issue;
            rf_src_p1 <= issue && !pipe_req;
            if (pipe_req) begin
                rf_wa_p1 <= wb_writereg;
                rf_wd_p1 <= wb_result;
            end else if (issue) begin
                rf_wa_p1 <= buf_reg[head_q];
                rf_wd_p1 <= buf_dat[head_q];
            end else begin
                rf_wa_p1 <= '0;
                rf_wd_p1 <= '0;
            end
        end
    end

    assign rf_we     = rf_we_p1;
    assign rf_src    = rf_src_p1;
    assign rf_wa     = rf_wa_p1;
    assign rf_wd     = rf_wd_p1;
    assign mdu_ready = ready_q;
    assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expected values.
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_regwrite;
    logic [4:0]  wb_writereg;
    logic [31:0] wb_result;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_writereg;
    logic [31:0] mdu_result;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        rf_src;
    logic        stall_req;
    logic [31:0] pend_mask;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_result(wb_result),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_writereg(mdu_writereg), .mdu_result(mdu_result),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_src(rf_src),
        .stall_req(stall_req), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic we, input logic [4:0] r, input logic [31:0] d);
        wb_regwrite = we; wb_writereg = r; wb_result = d;
    endtask

    task automatic mdu(input logic v, input logic [4:0] r, input logic [31:0] d);
        mdu_valid = v; mdu_writereg = r; mdu_result = d;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [4:0] wa,
                            input logic [31:0] wd, input logic src);
        check({tag, ".we"}, 32'(rf_we), 32'(we));
        if (we) begin
            check({tag, ".wa"}, 32'(rf_wa), 32'(wa));
            check({tag, ".wd"}, rf_wd, wd);
            check({tag, ".src"}, 32'(rf_src), 32'(src));
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        wb(0, 0, 0);
        mdu(0, 0, 0);
        tick(); tick();
        check("rst.ready", 32'(mdu_ready), 0);
        check("rst.we", 32'(rf_we), 0);
        check("rst.pend", pend_mask, 0);
        check("rst.stall", 32'(stall_req), 0);
        #3 rst_n = 1'b1;

        // Idle pipeline, single MDU result
        tick();
        check("t1.ready", 32'(mdu_ready), 1);
        mdu(1, 5, 32'hAA);
        tick();
        mdu(0, 0, 0);
        check_rf("t1.c1", 0, 0, 0, 0);
        check("t1.pend_c1", pend_mask, 32'h0000_0020);
        tick();
        check_rf("t1.c2", 1, 5, 32'hAA, 1);
        check("t1.pend_c2", pend_mask, 0);
        tick();
        check("t1.c3.we", 32'(rf_we), 0);

        // Starvation -> stall_req
        wb(1, 3, 32'h11);
        mdu(1, 7, 32'h22);
        tick();                                  // cycle 1
        mdu(0, 0, 0);
        check_rf("t2.c1", 1, 3, 32'h11, 0);
        check("t2.pend", pend_mask, 32'h0000_0080);
        tick(); tick(); tick();                  // cycle 4
        check("t2.stall_c4", 32'(stall_req), 0);
        tick();                                  // cycle 5
        check("t2.stall_c5", 32'(stall_req), 1);
        tick();                                  // cycle 6: pipeline still wins
        check("t2.stall_c6", 32'(stall_req), 1);
        check_rf("t2.c6", 1, 3, 32'h11, 0);
        wb(0, 0, 0);
        tick();                                  // cycle 7
        check_rf("t2.c7", 1, 7, 32'h22, 1);
        check("t2.stall_c7", 32'(stall_req), 0);
        check("t2.pend_c7", pend_mask, 0);
        tick();
        check("t2.c8.we", 32'(rf_we), 0);

        // WAW squash
        wb(1, 3, 32'h11);
        mdu(1, 9, 32'h55);
        tick();                                  // cycle 1
        mdu(0, 0, 0);
        check("t3.pend_c1", pend_mask, 32'h0000_0200);
        tick();                                  // cycle 2
        wb(1, 9, 32'h66);
        tick();                                  // cycle 3
        wb(0, 0, 0);
        check_rf("t3.c3", 1, 9, 32'h66, 0);
        check("t3.pend_c3", pend_mask, 0);
        tick();
        check("t3.c4.we", 32'(rf_we), 0);
        tick();
        check("t3.c5.we", 32'(rf_we), 0);
        check("t3.ready", 32'(mdu_ready), 1);

        // Full buffer, held offer, FIFO order
        wb(1, 4, 32'h44);
        mdu(1, 1, 32'h101);
        tick();                                  // cycle 1
        check("t4.ready_c1", 32'(mdu_ready), 1);
        mdu(1, 2, 32'h102);
        tick();                                  // cycle 2
        check("t4.ready_c2", 32'(mdu_ready), 0);
        check("t4.pend_c2", pend_mask, 32'h0000_0006);
        mdu(1, 3, 32'h103);
        tick();                                  // cycle 3
        check("t4.ready_c3", 32'(mdu_ready), 0);
        check_rf("t4.c3", 1, 4, 32'h44, 0);
        wb(0, 0, 0);
        tick();                                  // cycle 4
        check_rf("t4.c4", 1, 1, 32'h101, 1);
        check("t4.ready_c4", 32'(mdu_ready), 1);
        tick();                                  // cycle 5
        mdu(0, 0, 0);
        check_rf("t4.c5", 1, 2, 32'h102, 1);
        check("t4.pend_c5", pend_mask, 32'h0000_0008);
        tick();
        check_rf("t4.c6", 1, 3, 32'h103, 1);
        tick();
        check("t4.c7.we", 32'(rf_we), 0);
        check("t4.pend_c7", pend_mask, 0);

        // r0 writes from both sides
        wb(1, 0, 32'hDEAD);
        mdu(1, 0, 32'hBEEF);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("t5.we%0d", i), 32'(rf_we), 0);
            check($sformatf("t5.pend%0d", i), pend_mask, 0);
        end
        check("t5.stall", 32'(stall_req), 0);
        check("t5.ready", 32'(mdu_ready), 1);
        wb(0, 0, 0);
        mdu(0, 0, 0);
        tick();

        // Reset mid-operation
        wb(1, 4, 32'h44);
        mdu(1, 1, 32'hA1);
        tick();                                  // cycle 1
        mdu(1, 2, 32'hA2);
        tick();                                  // cycle 2
        mdu(0, 0, 0);
        tick(); tick(); tick();                  // cycle 5
        check("t6.stall", 32'(stall_req), 1);
        check("t6.pend", pend_mask, 32'h0000_0006);
        #2 rst_n = 1'b0;
        wb(0, 0, 0);
        #1;
        check("t6.rst.we", 32'(rf_we), 0);
        check("t6.rst.wa", 32'(rf_wa), 0);
        check("t6.rst.wd", rf_wd, 0);
        check("t6.rst.src", 32'(rf_src), 0);
        check("t6.rst.stall", 32'(stall_req), 0);
        check("t6.rst.pend", pend_mask, 0);
        check("t6.rst.ready", 32'(mdu_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t6.post.we%0d", i), 32'(rf_we), 0);
            check($sformatf("t6.post.ready%0d", i), 32'(mdu_ready), 1);
        end
        check("t6.post.pend", pend_mask, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
